// File: rtl/print_uart_tx_pkg.sv
// rtl/print_uart_tx_pkg.sv - shared print-path types and constants
// Purpose: UART state encoding, byte width and default baud divisor used by
//          the print UART transmitter and its byte FIFO.
package print_uart_tx_pkg;

  localparam int DATA_WID          = 8;
  localparam int CLKS_PER_BIT_DFLT = 278;  // 32 MHz / 115200

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/print_uart_tx_fifo.sv
// rtl/print_uart_tx_fifo.sv - show-ahead byte FIFO with early back-pressure
// Purpose: buffers bytes between the character fetcher and the UART.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   wr_data, push  byte and one-cycle push strobe
//   pop            advance the read pointer (ignored when empty)
//   rd_data        head byte, visible with no read latency
//   empty          no entries
//   almost_full    count >= DEPTH-1 (one slot of slack for the lagging strobe)
//   count          occupancy 0..DEPTH
//   drop_cnt       saturating count of pushes lost while completely full
module byte_fifo #(
  parameter int WIDTH = print_uart_tx_pkg::DATA_WID,
  parameter int DEPTH = 16,
  parameter int DEPL2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             almost_full,
  output logic [DEPL2:0]   count,
  output logic [7:0]       drop_cnt
);
  import print_uart_tx_pkg::*;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPL2-1:0] wr_ptr;
  logic [DEPL2-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full        = (count == (DEPL2+1)'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= (DEPL2+1)'(DEPTH-1));
  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;
  assign rd_data     = mem[rd_ptr];

  // Storage needs no reset; only entries behind a valid count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A push into a full FIFO is lost even if a pop happens on the same edge.
      if (push && full && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/print_uart_tx.sv
// rtl/print_uart_tx.sv - print-path byte FIFO drained by an 8N1 UART transmitter
// Purpose: accepts bytes from the character fetcher and serializes them LSB
//          first on the board TX line, back-to-back frames with no gap.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   data_i        byte to enqueue when queue_i is high
//   queue_i       push strobe, one byte per high cycle
//   fifofull_o    back-pressure (count >= FIFO_DEPTH-1)
//   txd_o         registered serial output, idle high
//   busy_o        FIFO non-empty or frame in progress
//   level_o       FIFO occupancy
//   dbg_drop_o    saturating count of dropped pushes
module print_uart_tx #(
  parameter int DATA_WID     = print_uart_tx_pkg::DATA_WID,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_DEPL2   = 4,
  parameter int CLKS_PER_BIT = print_uart_tx_pkg::CLKS_PER_BIT_DFLT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DATA_WID-1:0] data_i,
  input  logic                queue_i,
  output logic                fifofull_o,
  output logic                txd_o,
  output logic                busy_o,
  output logic [FIFO_DEPL2:0] level_o,
  output logic [7:0]          dbg_drop_o
);
  import print_uart_tx_pkg::*;

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_t         state, state_n;
  logic [BAUD_W-1:0]   baud, baud_n;
  logic [2:0]          bit_idx, bit_idx_n;
  logic [DATA_WID-1:0] shift, shift_n;
  logic                txd, txd_n;
  logic                pop;
  logic                empty;
  logic [DATA_WID-1:0] head;
  logic [FIFO_DEPL2:0] count;

  byte_fifo #(
    .WIDTH(DATA_WID),
    .DEPTH(FIFO_DEPTH),
    .DEPL2(FIFO_DEPL2)
  ) u_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .wr_data    (data_i),
    .push       (queue_i),
    .pop        (pop),
    .rd_data    (head),
    .empty      (empty),
    .almost_full(fifofull_o),
    .count      (count),
    .drop_cnt   (dbg_drop_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      txd     <= txd_n;
    end
  end

  // txd_n is the line level belonging to state_n, so the registered txd
  // switches on the same edge as the state it represents.
  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    txd_n     = txd;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        txd_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          baud_n  = '0;
          state_n = S_START;
          txd_n   = 1'b0;
        end
      end
      S_START: begin
        if (baud == BAUD_LAST) begin
          baud_n    = '0;
          bit_idx_n = '0;
          state_n   = S_DATA;
          txd_n     = shift[0];
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      S_DATA: begin
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          shift_n = shift >> 1;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
            txd_n   = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            txd_n     = shift_n[0];
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      S_STOP: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
            state_n = S_START;
            txd_n   = 1'b0;
          end else begin
            state_n = S_IDLE;
            txd_n   = 1'b1;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

  assign txd_o   = txd;
  assign level_o = count;
  assign busy_o  = (count != '0) || (state != S_IDLE);

endmodule

// File: tb/tb_print_uart_tx.sv
// tb/tb_print_uart_tx.sv - directed self-checking bench for print_uart_tx
module tb_print_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       queue = 1'b0;
  logic       fifofull;
  logic       txd;
  logic       busy;
  logic [2:0] level;
  logic [7:0] drop;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         rx_badstop = 0;

  print_uart_tx #(
    .DATA_WID(8),
    .FIFO_DEPTH(4),
    .FIFO_DEPL2(2),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .data_i    (data),
    .queue_i   (queue),
    .fifofull_o(fifofull),
    .txd_o     (txd),
    .busy_o    (busy),
    .level_o   (level),
    .dbg_drop_o(drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line receiver for 4 clocks per bit: samples each bit one cycle into it,
  // drops any frame during which reset was seen.
  initial begin : monitor
    logic [7:0] b;
    logic       stop_bit;
    logic       aborted;
    int         t0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && txd === 1'b0) begin
        t0 = cyc;
        aborted = 1'b0;
        b = 8'h00;
        stop_bit = 1'b0;
        for (int k = 1; k < 40; k++) begin
          @(negedge clk);
          if (rst !== 1'b0) aborted = 1'b1;
          if ((k % 4 == 1) && k >= 5 && k <= 33) b = {txd, b[7:1]};
          if (k == 37) stop_bit = txd;
        end
        if (!aborted) begin
          rx_q.push_back(b);
          rx_t.push_back(t0);
          if (stop_bit !== 1'b1) rx_badstop++;
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    queue = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (txd !== 1'b1) begin tests_failed++; $display("FAIL reset_txd: got %b expected 1", txd); end
    tests_run++; if (fifofull !== 1'b0) begin tests_failed++; $display("FAIL reset_fifofull: got %b expected 0", fifofull); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", level); end
    tests_run++; if (drop !== 8'd0) begin tests_failed++; $display("FAIL reset_drop: got %0d expected 0", drop); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (txd !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL reset_release: txd=%b busy=%b expected 1/0", txd, busy); end
  endtask

  task automatic test_single();
    logic [7:0] got;
    rx_q.delete(); rx_t.delete();
    @(negedge clk); data = 8'hA5; queue = 1'b1;
    @(negedge clk); queue = 1'b0;
    tests_run++; if (level !== 3'd1 || txd !== 1'b1) begin tests_failed++; $display("FAIL single_queued: level=%0d txd=%b expected 1/1", level, txd); end
    @(negedge clk);
    tests_run++; if (txd !== 1'b0) begin tests_failed++; $display("FAIL single_start: got %b expected 0", txd); end
    tests_run++; if (level !== 3'd0 || busy !== 1'b1) begin tests_failed++; $display("FAIL single_popped: level=%0d busy=%b expected 0/1", level, busy); end
    repeat (39) @(negedge clk);
    tests_run++; if (busy !== 1'b1 || txd !== 1'b1) begin tests_failed++; $display("FAIL single_last_stop: busy=%b txd=%b expected 1/1", busy, txd); end
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
    for (int c = 0; c < 20 && rx_q.size() < 1; c++) @(negedge clk);
    tests_run++; if (rx_q.size() != 1) begin tests_failed++; $display("FAIL single_frames: got %0d expected 1", rx_q.size()); end
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    tests_run++; if (got !== 8'hA5) begin tests_failed++; $display("FAIL single_byte: got %h expected a5", got); end
    tests_run++; if (rx_badstop != 0) begin tests_failed++; $display("FAIL single_stopbit: got %0d bad expected 0", rx_badstop); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    logic [2:0] peak = 3'd0;
    logic       full_seen = 1'b0;
    int         gap;
    rx_q.delete(); rx_t.delete();
    repeat (4) @(negedge clk);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (level > peak) peak = level;
      if (fifofull === 1'b1) full_seen = 1'b1;
      if (c < 3) begin data = 8'(8'h41 + c); queue = 1'b1; end else queue = 1'b0;
      if (c > 3 && rx_q.size() == 3 && busy === 1'b0) break;
    end
    tests_run++; if (rx_q.size() != 3) begin tests_failed++; $display("FAIL b2b_frames: got %0d expected 3", rx_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      tests_run++; if (got !== 8'(8'h41 + i)) begin tests_failed++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got, 8'(8'h41 + i)); end
    end
    for (int i = 1; i < 3; i++) begin
      gap = (i < rx_t.size()) ? rx_t[i] - rx_t[i-1] : -1;
      tests_run++; if (gap != 40) begin tests_failed++; $display("FAIL b2b_gap%0d: got %0d expected 40", i, gap); end
    end
    tests_run++; if (peak !== 3'd2) begin tests_failed++; $display("FAIL b2b_peak_level: got %0d expected 2", peak); end
    tests_run++; if (full_seen !== 1'b0) begin tests_failed++; $display("FAIL b2b_fifofull: got %b expected 0", full_seen); end
  endtask

  task automatic test_overflow();
    logic [7:0] got;
    int exp_lvl [6] = '{1, 1, 2, 3, 4, 4};
    int exp_full[6] = '{0, 0, 0, 1, 1, 1};
    rx_q.delete(); rx_t.delete();
    repeat (4) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      data = 8'(8'h10 + k); queue = 1'b1;
      @(negedge clk);
      tests_run++; if (level !== 3'(exp_lvl[k])) begin tests_failed++; $display("FAIL ovf_level%0d: got %0d expected %0d", k, level, exp_lvl[k]); end
      tests_run++; if (fifofull !== 1'(exp_full[k])) begin tests_failed++; $display("FAIL ovf_full%0d: got %b expected %0d", k, fifofull, exp_full[k]); end
    end
    queue = 1'b0;
    tests_run++; if (drop !== 8'd1) begin tests_failed++; $display("FAIL ovf_drop: got %0d expected 1", drop); end
    for (int c = 0; c < 400 && (rx_q.size() < 5 || busy === 1'b1); c++) @(negedge clk);
    repeat (50) @(negedge clk);
    tests_run++; if (rx_q.size() != 5) begin tests_failed++; $display("FAIL ovf_frames: got %0d expected 5", rx_q.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      tests_run++; if (got !== 8'(8'h10 + i)) begin tests_failed++; $display("FAIL ovf_byte%0d: got %h expected %h", i, got, 8'(8'h10 + i)); end
    end
  endtask

  task automatic test_flow_control();
    logic [7:0] got;
    logic       go = 1'b0;
    logic       full_seen = 1'b0;
    int         sent = 0;
    rx_q.delete(); rx_t.delete();
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (go) begin data = 8'(8'h30 + sent); queue = 1'b1; sent++; end else queue = 1'b0;
      if (fifofull === 1'b1) full_seen = 1'b1;
      go = (fifofull === 1'b0) && (sent < 20);
      if (sent == 20 && rx_q.size() == 20 && busy === 1'b0) break;
    end
    queue = 1'b0;
    tests_run++; if (drop !== 8'd0) begin tests_failed++; $display("FAIL flow_drop: got %0d expected 0", drop); end
    tests_run++; if (full_seen !== 1'b1) begin tests_failed++; $display("FAIL flow_fifofull_seen: got %b expected 1", full_seen); end
    tests_run++; if (rx_q.size() != 20) begin tests_failed++; $display("FAIL flow_frames: got %0d expected 20", rx_q.size()); end
    for (int i = 0; i < 20; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      tests_run++; if (got !== 8'(8'h30 + i)) begin tests_failed++; $display("FAIL flow_byte%0d: got %h expected %h", i, got, 8'(8'h30 + i)); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic stay_high = 1'b1;
    rx_q.delete(); rx_t.delete();
    repeat (4) @(negedge clk);
    data = 8'h11; queue = 1'b1;
    @(negedge clk); data = 8'h22;
    @(negedge clk); data = 8'h33;
    tests_run++; if (txd !== 1'b0) begin tests_failed++; $display("FAIL rstmid_start: got %b expected 0", txd); end
    @(negedge clk); queue = 1'b0;
    repeat (16) @(negedge clk);
    tests_run++; if (txd !== 1'b0 || level !== 3'd2) begin tests_failed++; $display("FAIL rstmid_bit3: txd=%b level=%0d expected 0/2", txd, level); end
    rst = 1'b1;
    #1;
    tests_run++; if (txd !== 1'b1) begin tests_failed++; $display("FAIL rstmid_txd: got %b expected 1", txd); end
    tests_run++; if (level !== 3'd0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_clear: level=%0d busy=%b expected 0/0", level, busy); end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) stay_high = 1'b0;
    end
    tests_run++; if (stay_high !== 1'b1) begin tests_failed++; $display("FAIL rstmid_no_resume: got %b expected 1", stay_high); end
    tests_run++; if (rx_q.size() != 0) begin tests_failed++; $display("FAIL rstmid_frames: got %0d expected 0", rx_q.size()); end
  endtask

  task automatic test_push_at_stop();
    logic [7:0] got;
    int         gap;
    rx_q.delete(); rx_t.delete();
    repeat (4) @(negedge clk);
    data = 8'h61; queue = 1'b1;
    @(negedge clk); queue = 1'b0;
    repeat (9) @(negedge clk);
    data = 8'h62; queue = 1'b1;
    @(negedge clk); queue = 1'b0;
    repeat (30) @(negedge clk);
    tests_run++; if (level !== 3'd1 || txd !== 1'b1 || fifofull !== 1'b0) begin tests_failed++; $display("FAIL stoppush_before: level=%0d txd=%b full=%b expected 1/1/0", level, txd, fifofull); end
    data = 8'h63; queue = 1'b1;
    @(negedge clk); queue = 1'b0;
    tests_run++; if (level !== 3'd1) begin tests_failed++; $display("FAIL stoppush_level: got %0d expected 1", level); end
    tests_run++; if (txd !== 1'b0) begin tests_failed++; $display("FAIL stoppush_no_gap: got %b expected 0", txd); end
    for (int c = 0; c < 200 && (rx_q.size() < 3 || busy === 1'b1); c++) @(negedge clk);
    tests_run++; if (rx_q.size() != 3) begin tests_failed++; $display("FAIL stoppush_frames: got %0d expected 3", rx_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      tests_run++; if (got !== 8'(8'h61 + i)) begin tests_failed++; $display("FAIL stoppush_byte%0d: got %h expected %h", i, got, 8'(8'h61 + i)); end
    end
    for (int i = 1; i < 3; i++) begin
      gap = (i < rx_t.size()) ? rx_t[i] - rx_t[i-1] : -1;
      tests_run++; if (gap != 40) begin tests_failed++; $display("FAIL stoppush_gap%0d: got %0d expected 40", i, gap); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_flow_control();
    test_reset_mid_frame();
    test_push_at_stop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/print_uart_tx.md
Name: print_uart_tx

Overview:
- Downstream stage of the character fetcher in the print path.
- Accepts bytes pushed with a one-cycle strobe into an internal byte FIFO and raises back-pressure.
- Drains the FIFO through an 8N1 UART transmitter (LSB first), producing the board's serial TX line.

Parameters:
- DATA_WID, 8: byte width; fixed at 8 for framing.
- FIFO_DEPTH, 16: FIFO entries; power of two, at least 4.
- FIFO_DEPL2, 4: log2(FIFO_DEPTH).
- CLKS_PER_BIT, 278: clock cycles per UART bit (32 MHz / 115200); at least 2.

Ports:
- clk_i  in  1  system clock, all logic rising-edge.
- rst_i  in  1  reset, asynchronous, active-high.
- data_i  in  DATA_WID  byte to enqueue, valid when queue_i=1.
- queue_i  in  1  push strobe, one byte per high cycle.
- fifofull_o  out  1  back-pressure to the fetcher.
- txd_o  out  1  UART serial output, idle high.
- busy_o  out  1  high when the FIFO is non-empty or a frame is in progress.
- level_o  out  FIFO_DEPL2+1  current FIFO occupancy.
- dbg_drop_o  out  8  count of pushes discarded while the FIFO was completely full.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high; on assertion all state clears immediately:
  - txd_o=1, fifofull_o=0, busy_o=0, level_o=0, dbg_drop_o=0.
  - FIFO pointers=0, UART state IDLE.
- Reset mid-frame abandons the frame; txd_o returns high in the same cycle rst_i rises.
- FIFO write and back-pressure:
  - Push accepted on a clk_i edge with queue_i=1 and count<FIFO_DEPTH.
  - The upstream strobe lags its full-check by one cycle, so back-pressure keeps one slot of slack: fifofull_o = (count >= FIFO_DEPTH-1), decoded combinationally from the count register.
  - Push with count==FIFO_DEPTH is dropped; dbg_drop_o increments and saturates at 255.
- FIFO read: show-ahead; the head byte is visible at rd_ptr with no read latency. Pop occurs only under UART control (below).
- Simultaneous push and pop: count is unchanged, both pointers advance. A push into an empty FIFO is poppable the next cycle.
- Pointers: FIFO_DEPL2 bits, natural wrap. count is FIFO_DEPL2+1 bits, range 0..FIFO_DEPTH. level_o = count.
- UART FSM states:
  - IDLE: txd=1. If FIFO non-empty: pop, load shift register with the head byte, clear baud counter, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit; after bit 7 go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. On the last cycle, if FIFO non-empty: pop, load, go to START (no gap). Otherwise go to IDLE.
- Timing:
  - First start bit appears on txd_o the cycle after the pop.
  - Back-to-back frame period is exactly 10*CLKS_PER_BIT cycles.
- txd_o is driven from a register (glitch-free).
- Baud counter: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
- busy_o = (count!=0) || (state!=IDLE), registered-derived.

Decomposition:
- Shared print package holds:
  - UART state encodings: S_IDLE=0, S_START=1, S_DATA=2, S_STOP=3.
  - Default CLKS_PER_BIT constant.
  - Byte width DATA_WID=8.
- Sub-module byte_fifo (storage, pointers, count, full/almost-full, drop counter); the top holds the UART FSM.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted):
1. Reset, then push 0xA5 once -> txd_o low one cycle after pop, then bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles; busy_o falls after the stop bit; total 40 cycles.
2. Push 0x41,0x42,0x43 on consecutive cycles -> three frames with no idle gap, 120 cycles start to end; level_o peaks at 2; fifofull_o never asserts.
3. Push 6 bytes on consecutive cycles ignoring fifofull_o -> fifofull_o high once count=3; FIFO fills to 4; dbg_drop_o=1; exactly 5 frames emitted, in order.
4. Upstream honouring fifofull_o (strobe one cycle after sampling low), 20 bytes -> no drops (dbg_drop_o=0), all 20 bytes serialized in order.
5. Assert rst_i during DATA bit 3 of a frame with 2 bytes queued -> txd_o=1 immediately; level_o=0; after release, txd_o stays high and no partial frame resumes.
6. Push coinciding with the stop-bit-end pop at count=1 -> level_o stays 1, next frame starts with no gap.
